snn_input_loader: RTL and testbench
===================================

SNN_INPUT_LOADER -- requirements
Module: snn_input_loader

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: in_valid  input  1  input frame word valid.
REQ-004 SHALL have port: Img  input  32  image word; sampled during image phase only.
REQ-005 SHALL have port: Kernel  input  32  kernel word; sampled during kernel phase only.
REQ-006 SHALL have port: Weight  input  32  weight word; sampled during weight phase only.
REQ-007 SHALL have port: Opt  input  2  option; sampled only on the first accepted word of a frame.
REQ-008 SHALL have port: release  input  1  compute core done with buffered frame.
REQ-009 SHALL have port: rd_sel  input  2  read bank: 0=img, 1=kernel, 2=weight, 3=none.
REQ-010 SHALL have port: rd_addr  input  7  word index in selected bank.
REQ-011 SHALL have port: rd_data  output  32  registered read data.
REQ-012 SHALL have port: opt_q  output  2  Opt latched for current frame.
REQ-013 SHALL have port: frame_done  output  1  one-cycle pulse, frame fully buffered.
REQ-014 SHALL have port: busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port: err_ovf  output  1  sticky protocol error; present only when the macro is defined.

Function
REQ-016 SHALL store one frame: 96 image words (img[0..95]), then 27 kernel words (ker[0..26]), then 4 weight words (w[0..3]), in arrival order.
REQ-017 SHALL implement states IDLE, LOAD_IMG, LOAD_KER, LOAD_W, FULL.
REQ-018 SHALL, in IDLE with in_valid=1: write Img to img[0], latch Opt into opt_q, set index=1, go to LOAD_IMG.
REQ-019 SHALL, in each LOAD state, accept one word per cycle with in_valid=1 and hold index and state when in_valid=0 (gaps allowed, no timeout).
REQ-020 SHALL move LOAD_IMG->LOAD_KER after img[95], LOAD_KER->LOAD_W after ker[26], and LOAD_W->FULL after w[3], with index reset to 0 on each phase change.
REQ-021 SHALL assert frame_done for exactly one cycle, the cycle after w[3] is written (first cycle in FULL).
REQ-022 SHALL, in FULL, ignore in_valid and leave all buffers and opt_q unchanged.
REQ-023 SHALL go FULL->IDLE on release=1; release in any other state SHALL be ignored.
REQ-024 SHALL, when release=1 and in_valid=1 coincide in FULL, take only FULL->IDLE; that in_valid word is dropped.
REQ-025 SHALL drive rd_data one cycle after rd_sel/rd_addr with the addressed word, in every state.
REQ-026 SHALL return rd_data=0 for rd_sel=3 or rd_addr beyond bank size (>=96, >=27, >=4).
REQ-027 SHALL return the previously stored value when reading a word being written in the same cycle (read-before-write).
REQ-028 SHALL retain opt_q and buffer contents through IDLE until overwritten by the next frame.

Reset
REQ-029 SHALL, on rst_n=0, immediately set state=IDLE, index=0, opt_q=0, rd_data=0, frame_done=0, busy=0, err_ovf=0; buffer contents need not be cleared.
REQ-030 SHALL, on reset mid-frame, discard the partial frame; the next in_valid after reset deasserts starts a new frame at img[0].

Configuration
REQ-031 SHALL, with SNN_LOADER_PROTO_CHK_EN defined, include err_ovf: set and held at 1 when in_valid=1 in FULL (including the REQ-024 coincidence), cleared only by reset.
REQ-032 SHALL, without SNN_LOADER_PROTO_CHK_EN, omit the err_ovf port and checker logic, with all other behaviour identical.

Verification
REQ-033 SHALL cover: reset with no stimulus -> rd_data=0, frame_done=0, busy=0, opt_q=0.
REQ-034 SHALL cover: continuous 127-word frame, Opt=2'b10, Img=i, Kernel=0x100+k, Weight=0x200+j -> frame_done pulses exactly once, 1 cycle after last weight; opt_q=2; rd_sel=1, rd_addr=26 -> 0x11A.
REQ-035 SHALL cover: 3-cycle in_valid gap after img[40] -> no word lost; img[41]=41, frame_done still after 127 accepted words.
REQ-036 SHALL cover: rd_sel=2, rd_addr=4 and rd_sel=3 -> rd_data=0; rd_sel=0, rd_addr=95 -> 95.
REQ-037 SHALL cover: rst_n pulsed low after img[50], then a full new frame -> frame_done once, img[0] equals new frame's first word.
REQ-038 SHALL cover: with macro, in_valid=1 for one cycle in FULL -> err_ovf=1 sticky, buffers unchanged; release -> IDLE, next frame loads normally.

Source files
------------

// File: rtl/snn_input_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : snn_input_loader                                             |
// | Description : Buffers one SNN frame (96 image, 27 kernel, 4 weight words)  |
// |               and serves registered random reads to the compute core.      |
// |               Define SNN_LOADER_PROTO_CHK_EN to add the sticky err_ovf     |
// |               flag for words offered while the buffer is full.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// The core-done input is named core_release because "release" is a reserved word.
module snn_input_loader (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [31:0] Img,
   input  logic [31:0] Kernel,
   input  logic [31:0] Weight,
   input  logic [1:0]  Opt,
   input  logic        core_release,
   input  logic [1:0]  rd_sel,
   input  logic [6:0]  rd_addr,
   output logic [31:0] rd_data,
   output logic [1:0]  opt_q,
   output logic        frame_done,
   output logic        busy
`ifdef SNN_LOADER_PROTO_CHK_EN
   ,
   output logic        err_ovf
`endif
);

   localparam logic [6:0] c_IMG_WORDS = 7'd96;
   localparam logic [6:0] c_KER_WORDS = 7'd27;
   localparam logic [6:0] c_W_WORDS   = 7'd4;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LOAD_IMG = 3'd1,
      S_LOAD_KER = 3'd2,
      S_LOAD_W   = 3'd3,
      S_FULL     = 3'd4
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [6:0]  r_idx;
   logic [6:0]  w_idx_nxt;
   logic [6:0]  w_wr_idx;
   logic        w_img_we;
   logic        w_ker_we;
   logic        w_w_we;
   logic        w_opt_we;
   logic        w_last_w;
   logic [1:0]  r_opt;
   logic        r_frame_done;
   logic [31:0] r_rd_data;

   logic [31:0] r_img_mem [0:95];
   logic [31:0] r_ker_mem [0:26];
   logic [31:0] r_w_mem   [0:3];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_idx        <= '0;
         r_opt        <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_idx        <= w_idx_nxt;
         r_frame_done <= w_last_w;
         if (w_opt_we) begin
            r_opt <= Opt;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_wr_idx    = r_idx;
      w_img_we    = 1'b0;
      w_ker_we    = 1'b0;
      w_w_we      = 1'b0;
      w_opt_we    = 1'b0;
      w_last_w    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (in_valid) begin
               w_img_we    = 1'b1;
               w_opt_we    = 1'b1;
               w_wr_idx    = '0;
               w_idx_nxt   = 7'd1;
               w_state_nxt = S_LOAD_IMG;
            end
         end
         S_LOAD_IMG: begin
            if (in_valid) begin
               w_img_we = 1'b1;
               if (r_idx == c_IMG_WORDS - 7'd1) begin
                  w_idx_nxt   = '0;
                  w_state_nxt = S_LOAD_KER;
               end else begin
                  w_idx_nxt = r_idx + 7'd1;
               end
            end
         end
         S_LOAD_KER: begin
            if (in_valid) begin
               w_ker_we = 1'b1;
               if (r_idx == c_KER_WORDS - 7'd1) begin
                  w_idx_nxt   = '0;
                  w_state_nxt = S_LOAD_W;
               end else begin
                  w_idx_nxt = r_idx + 7'd1;
               end
            end
         end
         S_LOAD_W: begin
            if (in_valid) begin
               w_w_we = 1'b1;
               if (r_idx == c_W_WORDS - 7'd1) begin
                  w_idx_nxt   = '0;
                  w_last_w    = 1'b1;
                  w_state_nxt = S_FULL;
               end else begin
                  w_idx_nxt = r_idx + 7'd1;
               end
            end
         end
         S_FULL: begin
            // A word offered together with release is dropped, not started.
            if (core_release) begin
               w_idx_nxt   = '0;
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_idx_nxt   = '0;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Buffers carry no reset so they map onto plain RAM.
   always_ff @(posedge clk) begin
      if (w_img_we) begin
         r_img_mem[w_wr_idx] <= Img;
      end
      if (w_ker_we) begin
         r_ker_mem[w_wr_idx[4:0]] <= Kernel;
      end
      if (w_w_we) begin
         r_w_mem[w_wr_idx[1:0]] <= Weight;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_data <= '0;
      end else begin
         case (rd_sel)
            2'd0:    r_rd_data <= (rd_addr < c_IMG_WORDS) ? r_img_mem[rd_addr] : '0;
            2'd1:    r_rd_data <= (rd_addr < c_KER_WORDS) ? r_ker_mem[rd_addr[4:0]] : '0;
            2'd2:    r_rd_data <= (rd_addr < c_W_WORDS) ? r_w_mem[rd_addr[1:0]] : '0;
            default: r_rd_data <= '0;
         endcase
      end
   end

`ifdef SNN_LOADER_PROTO_CHK_EN
   logic r_err_ovf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_ovf <= 1'b0;
      end else if ((r_state == S_FULL) && in_valid) begin
         r_err_ovf <= 1'b1;
      end
   end

   assign err_ovf = r_err_ovf;
`endif

   assign rd_data    = r_rd_data;
   assign opt_q      = r_opt;
   assign frame_done = r_frame_done;
   assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_snn_input_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_snn_input_loader                                          |
// | Description : Randomised self-checking bench; a word-count frame model     |
// |               predicts buffer contents, reads and frame_done.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_snn_input_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] Img;
   logic [31:0] Kernel;
   logic [31:0] Weight;
   logic [1:0]  Opt;
   logic        core_release;
   logic [1:0]  rd_sel;
   logic [6:0]  rd_addr;
   logic [31:0] rd_data;
   logic [1:0]  opt_q;
   logic        frame_done;
   logic        busy;
`ifdef SNN_LOADER_PROTO_CHK_EN
   logic        err_ovf;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   snn_input_loader dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .Img          (Img),
      .Kernel       (Kernel),
      .Weight       (Weight),
      .Opt          (Opt),
      .core_release (core_release),
      .rd_sel       (rd_sel),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .opt_q        (opt_q),
      .frame_done   (frame_done),
      .busy         (busy)
`ifdef SNN_LOADER_PROTO_CHK_EN
      ,
      .err_ovf      (err_ovf)
`endif
   );

   always #5 clk = ~clk;

   // Frame model: a frame is 127 words in arrival order, indexed by m_count.
   logic [31:0] m_img [96];
   logic [31:0] m_ker [27];
   logic [31:0] m_w   [4];
   logic [1:0]  m_opt;
   int          m_count;
   bit          m_full;
   bit          m_err;
   logic [31:0] exp_rd;
   logic        exp_done;
   int          done_seen;

   function automatic logic [31:0] model_read(input logic [1:0] sel, input logic [6:0] addr);
      int a;
      a = int'(addr);
      case (sel)
         2'd0:    return (a < 96) ? m_img[a] : 32'd0;
         2'd1:    return (a < 27) ? m_ker[a] : 32'd0;
         2'd2:    return (a < 4)  ? m_w[a]   : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_reset();
      m_count  = 0;
      m_full   = 1'b0;
      m_opt    = 2'd0;
      m_err    = 1'b0;
      exp_rd   = 32'd0;
      exp_done = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      exp_rd   = model_read(rd_sel, rd_addr);
      exp_done = 1'b0;
      if (m_full) begin
         if (in_valid) m_err = 1'b1;
         if (core_release) begin
            m_full  = 1'b0;
            m_count = 0;
         end
      end else if (in_valid) begin
         if (m_count == 0) m_opt = Opt;
         if (m_count < 96)       m_img[m_count] = Img;
         else if (m_count < 123) m_ker[m_count - 96] = Kernel;
         else                    m_w[m_count - 123] = Weight;
         m_count++;
         if (m_count == 127) begin
            m_full   = 1'b1;
            exp_done = 1'b1;
         end
      end
      #1;
      if (frame_done) done_seen++;
   endtask

   task automatic idle_inputs();
      in_valid     = 1'b0;
      core_release = 1'b0;
      Img          = $urandom;
      Kernel       = $urandom;
      Weight       = $urandom;
      Opt          = 2'($urandom);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      rd_sel  = 2'd3;
      rd_addr = 7'd0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (rd_data !== 32'd0) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
      n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_checks++; if (opt_q !== 2'd0) begin n_fail++; $display("FAIL reset_opt_q: got %0d expected 0", opt_q); end
`ifdef SNN_LOADER_PROTO_CHK_EN
      n_checks++; if (err_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_err_ovf: got %b expected 0", err_ovf); end
`endif
      rst_n = 1'b1;
   endtask

   task automatic test_continuous_frame();
      done_seen = 0;
      for (int i = 0; i < 127; i++) begin
         in_valid     = 1'b1;
         core_release = 1'b0;
         Opt    = (i == 0) ? 2'b10 : 2'($urandom);
         Img    = (i < 96) ? 32'(i) : $urandom;
         Kernel = (i >= 96 && i < 123) ? 32'h100 + 32'(i - 96) : $urandom;
         Weight = (i >= 123) ? 32'h200 + 32'(i - 123) : $urandom;
         // Only addresses already written in this first frame are read.
         rd_sel  = (i == 0) ? 2'd3 : 2'd0;
         rd_addr = (i == 0) ? 7'd0 : 7'($urandom_range(0, (i < 96) ? i - 1 : 127));
         step();
         n_checks++; if (rd_data !== exp_rd) begin n_fail++; $display("FAIL cont_rd word %0d: got %h expected %h", i, rd_data, exp_rd); end
         n_checks++; if (frame_done !== exp_done) begin n_fail++; $display("FAIL cont_done word %0d: got %b expected %b", i, frame_done, exp_done); end
      end
      idle_inputs();
      rd_sel  = 2'd1;
      rd_addr = 7'd26;
      step();
      n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL cont_done_width: got %b expected 0", frame_done); end
      n_checks++; if (rd_data !== 32'h11A) begin n_fail++; $display("FAIL cont_ker26: got %h expected 0000011a", rd_data); end
      step();
      n_checks++; if (done_seen !== 1) begin n_fail++; $display("FAIL cont_done_count: got %0d expected 1", done_seen); end
      n_checks++; if (opt_q !== 2'b10) begin n_fail++; $display("FAIL cont_opt_q: got %0d expected 2", opt_q); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL cont_busy_full: got %b expected 1", busy); end
   endtask

   task automatic test_read_bounds();
      logic [1:0] sels  [3] = '{2'd2, 2'd3, 2'd0};
      logic [6:0] addrs [3] = '{7'd4, 7'd0, 7'd95};
      logic [31:0] want [3] = '{32'd0, 32'd0, 32'd95};
      idle_inputs();
      for (int k = 0; k < 3; k++) begin
         rd_sel  = sels[k];
         rd_addr = addrs[k];
         step();
         n_checks++; if (rd_data !== want[k]) begin n_fail++; $display("FAIL bounds_%0d: got %h expected %h", k, rd_data, want[k]); end
      end
      for (int k = 0; k < 40; k++) begin
         rd_sel  = 2'($urandom);
         rd_addr = 7'($urandom);
         step();
         n_checks++; if (rd_data !== exp_rd) begin n_fail++; $display("FAIL rand_read sel %0d addr %0d: got %h expected %h", rd_sel, rd_addr, rd_data, exp_rd); end
      end
   endtask

   task automatic test_full_ignore();
      idle_inputs();
      in_valid = 1'b1;
      Opt      = 2'b01;
      rd_sel   = 2'd0;
      rd_addr  = 7'd0;
      step();
      in_valid = 1'b0;
      for (int k = 0; k < 6; k++) begin
         rd_sel  = 2'(k % 3);
         rd_addr = 7'(k / 3);
         step();
         n_checks++; if (rd_data !== exp_rd) begin n_fail++; $display("FAIL full_hold sel %0d addr %0d: got %h expected %h", rd_sel, rd_addr, rd_data, exp_rd); end
      end
      n_checks++; if (opt_q !== m_opt) begin n_fail++; $display("FAIL full_opt_hold: got %0d expected %0d", opt_q, m_opt); end
`ifdef SNN_LOADER_PROTO_CHK_EN
      n_checks++; if (err_ovf !== 1'b1) begin n_fail++; $display("FAIL err_ovf_set: got %b expected 1", err_ovf); end
`endif
      // Release with a coincident word: the word must be dropped.
      in_valid     = 1'b1;
      core_release = 1'b1;
      step();
      idle_inputs();
      step();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL release_busy: got %b expected 0", busy); end
      step();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL release_drop: got %b expected 0", busy); end
`ifdef SNN_LOADER_PROTO_CHK_EN
      n_checks++; if (err_ovf !== m_err) begin n_fail++; $display("FAIL err_ovf_sticky: got %b expected %b", err_ovf, m_err); end
`endif
   endtask

   task automatic test_gap_frame();
      int cyc = 0;
      int gap = 0;
      done_seen = 0;
      while (!m_full && cyc < 2000) begin
         if (m_count == 41 && gap < 3) begin
            in_valid = 1'b0;
            gap++;
         end else begin
            in_valid = ($urandom_range(0, 3) != 0);
         end
         core_release = ($urandom_range(0, 4) == 0);
         Img     = (m_count < 96) ? 32'(m_count) : $urandom;
         Kernel  = $urandom;
         Weight  = $urandom;
         Opt     = 2'($urandom);
         rd_sel  = 2'($urandom);
         rd_addr = 7'($urandom);
         step();
         cyc++;
         n_checks++; if (rd_data !== exp_rd) begin n_fail++; $display("FAIL gap_rd cyc %0d: got %h expected %h", cyc, rd_data, exp_rd); end
         n_checks++; if (frame_done !== exp_done) begin n_fail++; $display("FAIL gap_done cyc %0d: got %b expected %b", cyc, frame_done, exp_done); end
      end
      n_checks++; if (!m_full) begin n_fail++; $display("FAIL gap_timeout: got %0d words expected 127", m_count); end
      idle_inputs();
      rd_sel  = 2'd0;
      rd_addr = 7'd41;
      step();
      n_checks++; if (rd_data !== 32'd41) begin n_fail++; $display("FAIL gap_img41: got %h expected 00000029", rd_data); end
      n_checks++; if (done_seen !== 1) begin n_fail++; $display("FAIL gap_done_count: got %0d expected 1", done_seen); end
      n_checks++; if (opt_q !== m_opt) begin n_fail++; $display("FAIL gap_opt_q: got %0d expected %0d", opt_q, m_opt); end
      core_release = 1'b1;
      step();
      core_release = 1'b0;
   endtask

   task automatic test_reset_midframe();
      logic [31:0] first_word;
      idle_inputs();
      for (int i = 0; i < 51; i++) begin
         in_valid = 1'b1;
         Img      = $urandom;
         step();
      end
      idle_inputs();
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
      n_checks++; if (opt_q !== 2'd0) begin n_fail++; $display("FAIL midrst_opt_q: got %0d expected 0", opt_q); end
      n_checks++; if (rd_data !== 32'd0) begin n_fail++; $display("FAIL midrst_rd_data: got %h expected 0", rd_data); end
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      done_seen  = 0;
      first_word = $urandom;
      for (int i = 0; i < 127; i++) begin
         in_valid = 1'b1;
         Img      = (i == 0) ? first_word : $urandom;
         Kernel   = $urandom;
         Weight   = $urandom;
         Opt      = 2'($urandom);
         rd_sel   = 2'($urandom);
         rd_addr  = 7'($urandom);
         step();
         n_checks++; if (rd_data !== exp_rd) begin n_fail++; $display("FAIL midrst_rd word %0d: got %h expected %h", i, rd_data, exp_rd); end
      end
      idle_inputs();
      rd_sel  = 2'd0;
      rd_addr = 7'd0;
      step();
      n_checks++; if (rd_data !== first_word) begin n_fail++; $display("FAIL midrst_img0: got %h expected %h", rd_data, first_word); end
      step();
      n_checks++; if (done_seen !== 1) begin n_fail++; $display("FAIL midrst_done_count: got %0d expected 1", done_seen); end
`ifdef SNN_LOADER_PROTO_CHK_EN
      n_checks++; if (err_ovf !== 1'b0) begin n_fail++; $display("FAIL midrst_err_ovf: got %b expected 0", err_ovf); end
`endif
   endtask

   initial begin
      test_reset();
      test_continuous_frame();
      test_read_bounds();
      test_full_ignore();
      test_gap_frame();
      test_reset_midframe();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
